// File: rtl/rgb_led_array_pwm.sv
// Multi-LED RGB PWM driver: offloads changed per-LED HSL words to an external
// HSL-to-RGB converter over AXI4-S and turns the returned RGB words into PWM duty.
module rgb_led_array_pwm #(
  parameter int NR_OF_LEDS_P    = 4,
  parameter int COLOR_WIDTH_P   = 8,
  parameter int TID_BIT_WIDTH_P = 4,
  parameter int FADE_PRESCALE_P = 1024
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  output logic [NR_OF_LEDS_P-1:0]                   pwm_red,
  output logic [NR_OF_LEDS_P-1:0]                   pwm_green,
  output logic [NR_OF_LEDS_P-1:0]                   pwm_blue,
  input  logic [NR_OF_LEDS_P*3*COLOR_WIDTH_P-1:0]   cr_hsl,
  input  logic                                      cr_fade_enable,
  input  logic                                      axi4s_o_tready,
  output logic                                      axi4s_o_tvalid,
  output logic [3*COLOR_WIDTH_P-1:0]                axi4s_o_tdata,
  output logic [TID_BIT_WIDTH_P-1:0]                axi4s_o_tid,
  output logic                                      axi4s_i_tready,
  input  logic                                      axi4s_i_tvalid,
  input  logic [3*COLOR_WIDTH_P-1:0]                axi4s_i_tdata,
  input  logic [TID_BIT_WIDTH_P-1:0]                axi4s_i_tid
);

  localparam int NL    = NR_OF_LEDS_P;
  localparam int CW    = COLOR_WIDTH_P;
  localparam int HW    = 3 * COLOR_WIDTH_P;
  localparam int IDX_W = (NL > 1) ? $clog2(NL) : 1;
  localparam int PS_W  = (FADE_PRESCALE_P > 1) ? $clog2(FADE_PRESCALE_P) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           sel_q, sel_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic                       o_tvalid_q, o_tvalid_d;
  logic [HW-1:0]              o_tdata_q, o_tdata_d;
  logic [TID_BIT_WIDTH_P-1:0] o_tid_q, o_tid_d;
  logic                       i_tready_q, i_tready_d;
  logic                       handshake;

  logic [HW-1:0]              hsl_word [NL];
  logic [HW-1:0]              sent_hsl_q [NL];
  logic [HW-1:0]              sent_hsl_d [NL];
  logic [HW-1:0]              target_q [NL];
  logic [HW-1:0]              target_d [NL];
  logic [HW-1:0]              duty_q [NL];
  logic [HW-1:0]              duty_d [NL];
  logic [NL-1:0]              pending;

  logic                       any_pending;
  logic [IDX_W-1:0]           arb_idx;
  logic [IDX_W:0]             scan_idx;

  logic [CW-1:0]              pwm_cnt_q, pwm_cnt_d;
  logic [PS_W-1:0]            presc_q, presc_d;
  logic                       fade_step;
  logic [NL-1:0]              pwm_red_q, pwm_red_d;
  logic [NL-1:0]              pwm_green_q, pwm_green_d;
  logic [NL-1:0]              pwm_blue_q, pwm_blue_d;

  // Moves each colour one step toward its target, saturating at the target.
  function automatic logic [HW-1:0] next_duty(
    input logic [HW-1:0] duty,
    input logic [HW-1:0] tgt,
    input logic          fade_en,
    input logic          step
  );
    logic [CW-1:0] d_c;
    logic [CW-1:0] t_c;
    next_duty = duty;
    if (!fade_en) begin
      next_duty = tgt;
    end else if (step) begin
      for (int c = 0; c < 3; c++) begin
        d_c = duty[c*CW +: CW];
        t_c = tgt[c*CW +: CW];
        if (d_c < t_c) begin
          next_duty[c*CW +: CW] = d_c + 1'b1;
        end else if (d_c > t_c) begin
          next_duty[c*CW +: CW] = d_c - 1'b1;
        end
      end
    end
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_led
      assign hsl_word[gi]   = cr_hsl[gi*HW +: HW];
      assign pending[gi]    = (hsl_word[gi] != sent_hsl_q[gi]);
      // Record what was actually transmitted, not the live register.
      assign sent_hsl_d[gi] = (handshake && (sel_q == IDX_W'(gi))) ? o_tdata_q : sent_hsl_q[gi];
      // Out-of-range TIDs never match any LED and are dropped here.
      assign target_d[gi]   = (axi4s_i_tvalid && i_tready_q &&
                               (axi4s_i_tid == TID_BIT_WIDTH_P'(gi))) ? axi4s_i_tdata : target_q[gi];
      assign duty_d[gi]     = next_duty(duty_q[gi], target_q[gi], cr_fade_enable, fade_step);
      assign pwm_red_d[gi]   = (pwm_cnt_q < duty_q[gi][CW-1:0]);
      assign pwm_green_d[gi] = (pwm_cnt_q < duty_q[gi][2*CW-1:CW]);
      assign pwm_blue_d[gi]  = (pwm_cnt_q < duty_q[gi][HW-1:2*CW]);
    end
  endgenerate

  // Round-robin pick: first pending LED at or after rr_ptr, wrapping.
  always_comb begin
    any_pending = 1'b0;
    arb_idx     = '0;
    scan_idx    = '0;
    for (int k = 0; k < NL; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (scan_idx >= (IDX_W+1)'(NL)) begin
        scan_idx = scan_idx - (IDX_W+1)'(NL);
      end
      if (!any_pending && pending[scan_idx[IDX_W-1:0]]) begin
        any_pending = 1'b1;
        arb_idx     = scan_idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    o_tvalid_d = o_tvalid_q;
    o_tdata_d  = o_tdata_q;
    o_tid_d    = o_tid_q;
    handshake  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_pending) begin
          sel_d      = arb_idx;
          o_tdata_d  = hsl_word[arb_idx];
          o_tid_d    = TID_BIT_WIDTH_P'(arb_idx);
          o_tvalid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (axi4s_o_tready) begin
          handshake  = 1'b1;
          o_tvalid_d = 1'b0;
          rr_ptr_d   = (sel_q == IDX_W'(NL-1)) ? '0 : sel_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_tready_d = 1'b1;
  assign fade_step  = (presc_q == PS_W'(FADE_PRESCALE_P-1));
  assign presc_d    = fade_step ? '0 : presc_q + 1'b1;
  assign pwm_cnt_d  = pwm_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      o_tvalid_q  <= 1'b0;
      o_tdata_q   <= '0;
      o_tid_q     <= '0;
      i_tready_q  <= 1'b0;
      pwm_cnt_q   <= '0;
      presc_q     <= '0;
      pwm_red_q   <= '0;
      pwm_green_q <= '0;
      pwm_blue_q  <= '0;
      for (int i = 0; i < NL; i++) begin
        sent_hsl_q[i] <= '0;
        target_q[i]   <= '0;
        duty_q[i]     <= '0;
      end
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      o_tvalid_q  <= o_tvalid_d;
      o_tdata_q   <= o_tdata_d;
      o_tid_q     <= o_tid_d;
      i_tready_q  <= i_tready_d;
      pwm_cnt_q   <= pwm_cnt_d;
      presc_q     <= presc_d;
      pwm_red_q   <= pwm_red_d;
      pwm_green_q <= pwm_green_d;
      pwm_blue_q  <= pwm_blue_d;
      for (int i = 0; i < NL; i++) begin
        sent_hsl_q[i] <= sent_hsl_d[i];
        target_q[i]   <= target_d[i];
        duty_q[i]     <= duty_d[i];
      end
    end
  end

  assign axi4s_o_tvalid = o_tvalid_q;
  assign axi4s_o_tdata  = o_tdata_q;
  assign axi4s_o_tid    = o_tid_q;
  assign axi4s_i_tready = i_tready_q;
  assign pwm_red        = pwm_red_q;
  assign pwm_green      = pwm_green_q;
  assign pwm_blue       = pwm_blue_q;

endmodule

// File: tb/tb_rgb_led_array_pwm.sv
// Bench for rgb_led_array_pwm: directed scenarios plus random traffic, every cycle
// compared against a transaction-level reference model of requests, targets and PWM.
module tb_rgb_led_array_pwm;

  localparam int N = 4;
  localparam int W = 8;
  localparam int P = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  pwm_red, pwm_green, pwm_blue;
  logic [N*24-1:0] cr_hsl = '0;
  logic          fade_en = 1'b0;
  logic          o_tready = 1'b1;
  logic          o_tvalid;
  logic [23:0]   o_tdata;
  logic [3:0]    o_tid;
  logic          i_tready;
  logic          i_tvalid = 1'b0;
  logic [23:0]   i_tdata = '0;
  logic [3:0]    i_tid = '0;

  rgb_led_array_pwm #(
    .NR_OF_LEDS_P(N), .COLOR_WIDTH_P(W), .TID_BIT_WIDTH_P(4), .FADE_PRESCALE_P(P)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pwm_red(pwm_red), .pwm_green(pwm_green), .pwm_blue(pwm_blue),
    .cr_hsl(cr_hsl), .cr_fade_enable(fade_en),
    .axi4s_o_tready(o_tready), .axi4s_o_tvalid(o_tvalid),
    .axi4s_o_tdata(o_tdata), .axi4s_o_tid(o_tid),
    .axi4s_i_tready(i_tready), .axi4s_i_tvalid(i_tvalid),
    .axi4s_i_tdata(i_tdata), .axi4s_i_tid(i_tid)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [23:0] m_sent [N];
  logic [23:0] m_target [N];
  logic [23:0] m_duty [N];
  int          m_rr, m_tid, m_cnt, m_presc;
  bit          m_busy, m_itready;
  logic [23:0] m_tdata;
  logic [N-1:0] m_pr, m_pg, m_pb;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] hsl_of(input int i);
    return cr_hsl[i*24 +: 24];
  endfunction

  task automatic set_hsl(input int i, input logic [23:0] v);
    cr_hsl[i*24 +: 24] = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sent[i] = '0; m_target[i] = '0; m_duty[i] = '0;
    end
    m_rr = 0; m_tid = 0; m_cnt = 0; m_presc = 0;
    m_busy = 0; m_itready = 0; m_tdata = '0;
    m_pr = '0; m_pg = '0; m_pb = '0;
  endtask

  // One clock edge of the specified behaviour, using the inputs held before the edge.
  task automatic model_step();
    if (m_busy) begin
      if (o_tready) begin
        m_sent[m_tid] = m_tdata;
        m_busy = 0;
        m_rr = (m_tid + 1) % N;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (!m_busy && hsl_of(idx) != m_sent[idx]) begin
          m_busy = 1; m_tid = idx; m_tdata = hsl_of(idx);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      m_pr[i] = (m_cnt < int'(m_duty[i][7:0]));
      m_pg[i] = (m_cnt < int'(m_duty[i][15:8]));
      m_pb[i] = (m_cnt < int'(m_duty[i][23:16]));
    end
    m_cnt = (m_cnt + 1) % 256;
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < 3; c++) begin
        int cur, tgt;
        cur = int'(m_duty[i][c*8 +: 8]);
        tgt = int'(m_target[i][c*8 +: 8]);
        if (!fade_en) cur = tgt;
        else if (m_presc == P - 1) begin
          if (cur < tgt) cur++;
          else if (cur > tgt) cur--;
        end
        m_duty[i][c*8 +: 8] = 8'(cur);
      end
    end
    m_presc = (m_presc + 1) % P;
    if (i_tvalid && m_itready && int'(i_tid) < N) m_target[i_tid] = i_tdata;
    m_itready = 1;
  endtask

  task automatic compare_all();
    chk("o_tvalid", o_tvalid, m_busy);
    if (m_busy) begin
      chk("o_tid", o_tid, m_tid);
      chk("o_tdata", o_tdata, m_tdata);
    end
    chk("i_tready", i_tready, m_itready);
    chk("pwm_red", pwm_red, m_pr);
    chk("pwm_green", pwm_green, m_pg);
    chk("pwm_blue", pwm_blue, m_pb);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    compare_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order[$];
    int exp_order[3];
    int hr, hg, hb, first_nz;
    bit prev;
    exp_order = '{0, 1, 3};
    model_reset();

    // Reset with all registers zero: nothing is requested.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_i_tready", i_tready, 0);
    chk("rst_pwm", {pwm_red, pwm_green, pwm_blue}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("i_tready_first_clk", i_tready, 1);
    repeat (20) tick();

    // Three LEDs change together: issued in index order with idle gaps.
    set_hsl(0, 24'h112233); set_hsl(1, 24'h445566); set_hsl(3, 24'h778899);
    prev = o_tvalid;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (o_tvalid && !prev) order.push_back(int'(o_tid));
      prev = o_tvalid;
    end
    chk("order_len", order.size(), 3);
    for (int j = 0; j < 3; j++) chk("order_tid", (j < order.size()) ? order[j] : 32'hFFFF, exp_order[j]);

    // Backpressure: request held stable while tready is low.
    o_tready = 1'b0;
    set_hsl(1, 24'hABCDEF);
    for (int j = 0; j < 10 && !o_tvalid; j++) tick();
    chk("bp_valid", o_tvalid, 1);
    repeat (5) begin
      tick();
      chk("bp_hold_tid", o_tid, 1);
      chk("bp_hold_tdata", o_tdata, 24'hABCDEF);
    end
    o_tready = 1'b1;
    repeat (3) tick();

    // Single LED request and red-only response.
    set_hsl(2, 24'h204080);
    tick();
    chk("req2_tvalid", o_tvalid, 1);
    chk("req2_tid", o_tid, 2);
    chk("req2_tdata", o_tdata, 24'h204080);
    tick();
    chk("req2_done", o_tvalid, 0);
    i_tvalid = 1'b1; i_tid = 4'd2; i_tdata = 24'h0000FF;
    tick();
    i_tvalid = 1'b0;
    repeat (4) tick();
    hr = 0; hg = 0; hb = 0;
    repeat (256) begin
      tick();
      hr += int'(pwm_red[2]); hg += int'(pwm_green[2]); hb += int'(pwm_blue[2]);
    end
    chk("led2_red_high", hr, 255);
    chk("led2_green_high", hg, 0);
    chk("led2_blue_high", hb, 0);

    // Register changes while its request is held: old word first, then new.
    o_tready = 1'b0;
    set_hsl(0, 24'h0A0B0C);
    tick();
    chk("a_tdata", o_tdata, 24'h0A0B0C);
    set_hsl(0, 24'h0D0E0F);
    repeat (3) tick();
    chk("a_held_tdata", o_tdata, 24'h0A0B0C);
    chk("a_held_tid", o_tid, 0);
    o_tready = 1'b1;
    tick();
    chk("a_sent_gap", o_tvalid, 0);
    tick();
    chk("b_tvalid", o_tvalid, 1);
    chk("b_tdata", o_tdata, 24'h0D0E0F);
    repeat (8) tick();
    chk("b_settled", o_tvalid, 0);

    // Fade: red of LED1 ramps 0x10 -> 0x13; out-of-range TID ignored.
    i_tvalid = 1'b1; i_tid = 4'd1; i_tdata = 24'h000010;
    tick();
    i_tvalid = 1'b0;
    repeat (2) tick();
    fade_en = 1'b1;
    i_tvalid = 1'b1; i_tdata = 24'h000013;
    tick();
    i_tvalid = 1'b0;
    repeat (30) tick();
    i_tvalid = 1'b1; i_tid = 4'd7; i_tdata = 24'hFFFFFF;
    tick();
    i_tvalid = 1'b0;
    repeat (3) tick();
    hr = 0; hg = 0; hb = 0;
    repeat (256) begin
      tick();
      hr += int'(pwm_red[1]); hg += int'(pwm_green[1]); hb += int'(pwm_red[2]);
    end
    chk("fade_red1_high", hr, 19);
    chk("fade_green1_high", hg, 0);
    chk("tid7_red2_high", hb, 255);

    // Random traffic against the model.
    repeat (1500) begin
      if ($urandom_range(7) == 0) set_hsl(int'($urandom_range(N-1)), 24'($urandom));
      o_tready = ($urandom_range(3) != 0);
      i_tvalid = ($urandom_range(3) == 0);
      i_tid    = 4'($urandom_range(7));
      i_tdata  = 24'($urandom);
      if ($urandom_range(63) == 0) fade_en = ~fade_en;
      tick();
    end
    i_tvalid = 1'b0;

    // Asynchronous reset while a request is held.
    o_tready = 1'b0;
    set_hsl(2, ~hsl_of(2));
    for (int j = 0; j < 10 && !o_tvalid; j++) tick();
    chk("pre_rst_valid", o_tvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", o_tvalid, 0);
    chk("async_rst_i_tready", i_tready, 0);
    chk("async_rst_pwm", {pwm_red, pwm_green, pwm_blue}, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    o_tready = 1'b1;
    first_nz = N;
    for (int i = N - 1; i >= 0; i--) if (hsl_of(i) != 24'h0) first_nz = i;
    for (int j = 0; j < 10 && !o_tvalid; j++) tick();
    chk("resend_first_tid", o_tid, first_nz);
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rgb_led_array_pwm.md
Name: rgb_led_array_pwm

Overview:
Multi-LED successor to the single-LED PWM controller. Drives NR_OF_LEDS_P RGB LEDs from per-LED HSL control registers. Changed HSL words are offloaded to an external HSL-to-RGB converter over AXI4-S, tagged with the LED index in TID. Returned RGB words, routed by TID, become per-LED duty targets, with an optional linear fade. Sits between the register bank and the board LED pins.

Parameters:
NR_OF_LEDS_P, 4, number of RGB LEDs (>=1)
COLOR_WIDTH_P, 8, bits per colour component and PWM counter width
TID_BIT_WIDTH_P, 4, AXI4-S TID width; must be >= clog2(NR_OF_LEDS_P)
FADE_PRESCALE_P, 1024, clk cycles per fade step (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
pwm_red  out  NR_OF_LEDS_P  red pin per LED
pwm_green  out  NR_OF_LEDS_P  green pin per LED
pwm_blue  out  NR_OF_LEDS_P  blue pin per LED
cr_hsl  in  NR_OF_LEDS_P*3*COLOR_WIDTH_P  LED i at slice i: {light,sat,hue}, hue in LSBs
cr_fade_enable  in  1  1 = duty ramps toward target, 0 = duty jumps
axi4s_o_tready  in  1  converter ready
axi4s_o_tvalid  out  1  HSL request valid
axi4s_o_tdata  out  3*COLOR_WIDTH_P  HSL word {l,s,h}
axi4s_o_tid  out  TID_BIT_WIDTH_P  LED index of request
axi4s_i_tready  out  1  RGB response ready
axi4s_i_tvalid  in  1  RGB response valid
axi4s_i_tdata  in  3*COLOR_WIDTH_P  {blue,green,red}, red in LSBs
axi4s_i_tid  in  TID_BIT_WIDTH_P  LED index of response

Behaviour:
- Reset: all outputs 0; sent_hsl[i], target[i], duty[i], PWM counter, prescaler, rr pointer cleared; FSM IDLE. Async assertion mid-transfer drops tvalid immediately; no in-flight state survives.
- Change detect: pending[i] = (cr_hsl[i] != sent_hsl[i]), combinational. Because sent_hsl resets to 0, nonzero registers are sent after reset.
- Request FSM, states IDLE and SEND:
  - IDLE: if any pending, choose the first pending index at or after rr_ptr, modulo NR_OF_LEDS_P. Next cycle: tdata <= cr_hsl[sel], tid <= sel, tvalid <= 1, go to SEND. One cycle of latency from change to tvalid.
  - SEND: tdata, tid and tvalid are held stable until tready. On handshake: sent_hsl[sel] <= the transmitted tdata (not the live cr_hsl), tvalid <= 0, rr_ptr <= sel+1 wrapping at NR_OF_LEDS_P, go to IDLE.
  - Back-to-back requests for different LEDs have a minimum of 1 idle cycle between them.
  - If cr_hsl[sel] changes while in SEND, the held word is still sent. The mismatch then re-pends, and the new value is sent on a later arbitration.
  - Round-robin guarantees that a continuously changing LED cannot starve the others.
- Response path:
  - axi4s_i_tready is 0 in reset and 1 from the first clock after reset release. No backpressure.
  - On i handshake with tid < NR_OF_LEDS_P: target[tid] <= tdata.
  - On i handshake with tid >= NR_OF_LEDS_P: the beat is dropped silently.
- Duty update:
  - cr_fade_enable=0: duty[i] <= target[i] every cycle, one cycle after target update.
  - cr_fade_enable=1: the prescaler counts 0..FADE_PRESCALE_P-1 and wraps. On the wrap cycle, each colour of each LED moves duty by +1 toward target if below, -1 if above, and holds if equal. There is no overshoot and no wrap-around in duty arithmetic.
  - Toggling fade enable takes effect on the next cycle.
- PWM:
  - One shared free-running counter, COLOR_WIDTH_P bits, wrapping from 2^W-1 to 0.
  - pwm_x[i] is registered: (counter < duty_x[i]).
  - duty 0 gives constant 0; duty 2^W-1 gives high for 2^W-1 of every 2^W cycles.
  - Duty changes apply from the next counter value, so no glitch-free period alignment is required.

Test Plan:
- Reset, all cr_hsl=0, tready=1 -> no tvalid ever; all pwm 0; i_tready=1 from the first post-reset clock.
- LED2 cr_hsl=0x204080, tready=1 -> tvalid one cycle later with tid=2, tdata=0x204080 -> response tid=2, tdata=0x0000FF gives pwm_red[2] high 255/256 cycles, green and blue low.
- LEDs 0,1,3 changed in the same cycle, tready=1 -> requests issued in tid order 0,1,3, each separated by at least 1 idle cycle; tready held low 5 cycles -> tdata/tid stable throughout.
- LED0 changed to A, then to B during SEND with tready=0 -> A transmitted, then B transmitted as a separate request; final sent_hsl[0]=B.
- fade_enable=1, FADE_PRESCALE_P=4, duty_red[1]=0x10, response target 0x13 -> duty steps 0x11,0x12,0x13 at 4-cycle intervals and then holds; response with tid=7 (NR=4) -> no target changes.
- rst_n pulsed low while in SEND with tvalid=1 -> tvalid 0 asynchronously; after release, pending LEDs are re-sent from index 0.
